// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the AXI-Stream multiplier (sign helper also used by the divider).
// Latency: n/a (package only).
// Backpressure: n/a. Build option MULT_RADIX4_EN retires two multiplier bits per CALC cycle instead of one.
package mult_pkg;

    // Core sequencer states; encoding is fixed so debug dumps line up with the divider
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_OUT  = 2'd3
    } mult_state_t;

    // Multiplier bits consumed per CALC cycle
`ifdef MULT_RADIX4_EN
    localparam int DIGIT_BITS = 2;
`else
    localparam int DIGIT_BITS = 1;
`endif

    // Maps a symbol parameter ("signed"/"unsigned") to a two's-complement flag
    function automatic bit is_signed(input string symbol);
        return (symbol == "signed");
    endfunction

    // Number of CALC cycles needed to retire all width_b multiplier bits
    function automatic int calc_iters(input int width_b);
        return (width_b + DIGIT_BITS - 1) / DIGIT_BITS;
    endfunction

endpackage

// File: rtl/mult_axis_buf.sv
// One-entry AXI-Stream holding register for a single operand channel.
// Latency: data visible on the edge after the handshake; cleared by the core on load.
// Backpressure: s_tready is low while full or while rst is high; one beat of storage.
module mult_axis_buf #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic             clear,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    // Ready depends only on our own occupancy, so a full slot never collides with a load
    assign s_tready = ~rst & ~full;

    // Capture a beat when empty; the core's load empties the slot again
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (s_tvalid && s_tready) begin
            full <= 1'b1;
            data <= s_tdata;
        end
    end

endmodule

// File: rtl/mult_axis.sv
// Iterative shift-add fixed-point multiplier with AXI-Stream operand and product channels.
// Latency: product valid calc_iters(WIDTH_B)+2 edges after the later operand handshake (idle core).
// Backpressure: one operand pair buffered while busy; m_axis_tready low stalls indefinitely.
// Build option: MULT_RADIX4_EN (radix-4 CALC, results bit-identical to radix-2).
module mult_axis
    import mult_pkg::*;
#(
    parameter string SYMBOL_A = "signed",
    parameter string SYMBOL_B = "signed",
    parameter int    WIDTH_A  = 16,
    parameter int    WIDTH_B  = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [WIDTH_A-1:0]         s_axis_a_tdata,
    input  logic                       s_axis_a_tvalid,
    output logic                       s_axis_a_tready,
    input  logic [WIDTH_B-1:0]         s_axis_b_tdata,
    input  logic                       s_axis_b_tvalid,
    output logic                       s_axis_b_tready,
    output logic [WIDTH_A+WIDTH_B-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready
);

    localparam bit A_SIGNED = is_signed(SYMBOL_A);
    localparam bit B_SIGNED = is_signed(SYMBOL_B);
    localparam int OUT_W    = WIDTH_A + WIDTH_B;
    localparam int ITERS    = calc_iters(WIDTH_B);
    // Multiplier field of the accumulator, padded up to a whole number of digits
    localparam int LO_W     = ITERS * DIGIT_BITS;
    // Partial-sum field: one spare bit per retired multiplier bit absorbs the add carry
    localparam int HI_W     = WIDTH_A + DIGIT_BITS;
    localparam int ACC_W    = HI_W + LO_W;
    localparam int CNT_W    = $clog2(ITERS) + 1;

    // Operand holding registers
    logic [WIDTH_A-1:0] buf_a_dat;
    logic               buf_a_full;
    logic [WIDTH_B-1:0] buf_b_dat;
    logic               buf_b_full;

    // Sequencer
    mult_state_t state;
    mult_state_t state_nxt;
    logic        core_load;
    logic        calc_last;

    // Magnitude decode of the buffered operands
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH_A-1:0] a_mag;
    logic [WIDTH_B-1:0] b_mag;

    // Core datapath
    logic [WIDTH_A-1:0] mag_a_q;
    logic               neg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_nxt;
    logic [HI_W-1:0]    addend;
    logic [HI_W-1:0]    sum;
    logic [OUT_W-1:0]   product;
    logic [OUT_W-1:0]   tdata_q;
`ifdef MULT_RADIX4_EN
    logic [HI_W-1:0]    a3_q;
`endif

    mult_axis_buf #(
        .WIDTH (WIDTH_A)
    ) u_buf_a (
        .clk      (aclk),
        .rst      (areset),
        .s_tdata  (s_axis_a_tdata),
        .s_tvalid (s_axis_a_tvalid),
        .s_tready (s_axis_a_tready),
        .clear    (core_load),
        .data     (buf_a_dat),
        .full     (buf_a_full)
    );

    mult_axis_buf #(
        .WIDTH (WIDTH_B)
    ) u_buf_b (
        .clk      (aclk),
        .rst      (areset),
        .s_tdata  (s_axis_b_tdata),
        .s_tvalid (s_axis_b_tvalid),
        .s_tready (s_axis_b_tready),
        .clear    (core_load),
        .data     (buf_b_dat),
        .full     (buf_b_full)
    );

    // Unsigned magnitudes: -2^(W-1) negates to itself, which read unsigned is exactly 2^(W-1)
    assign a_neg = A_SIGNED && buf_a_dat[WIDTH_A-1];
    assign b_neg = B_SIGNED && buf_b_dat[WIDTH_B-1];
    assign a_mag = a_neg ? -buf_a_dat : buf_a_dat;
    assign b_mag = b_neg ? -buf_b_dat : buf_b_dat;

    assign calc_last = (cnt_q == CNT_W'(ITERS - 1));
    assign product   = acc_q[OUT_W-1:0];

    // State register
    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: load when both operands are present, hold the product until accepted
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (buf_a_full && buf_b_full) state_nxt = ST_CALC;
            ST_CALC: if (calc_last)                state_nxt = ST_SIGN;
            ST_SIGN:                               state_nxt = ST_OUT;
            ST_OUT:  if (m_axis_tready)            state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded controls: core load strobe and product valid
    always_comb begin
        core_load     = (state == ST_IDLE) && buf_a_full && buf_b_full;
        m_axis_tvalid = (state == ST_OUT);
    end

    // One CALC step: add the selected multiple of |A| to the upper field, shift one digit right
    always_comb begin
        addend = '0;
`ifdef MULT_RADIX4_EN
        case (acc_q[1:0])
            2'd1:    addend = HI_W'(mag_a_q);
            2'd2:    addend = HI_W'({mag_a_q, 1'b0});
            2'd3:    addend = a3_q;
            default: addend = '0;
        endcase
`else
        if (acc_q[0]) addend = HI_W'(mag_a_q);
`endif
        sum     = acc_q[ACC_W-1:LO_W] + addend;
        acc_nxt = {{DIGIT_BITS{1'b0}}, sum, acc_q[LO_W-1:DIGIT_BITS]};
    end

    // Core registers: load magnitudes and result sign, then iterate during CALC
    always_ff @(posedge aclk) begin
        if (areset) begin
            mag_a_q <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
`ifdef MULT_RADIX4_EN
            a3_q    <= '0;
`endif
        end else if (core_load) begin
            mag_a_q <= a_mag;
            neg_q   <= a_neg ^ b_neg;
            cnt_q   <= '0;
            acc_q   <= ACC_W'(b_mag);
`ifdef MULT_RADIX4_EN
            a3_q    <= HI_W'(a_mag) + HI_W'({a_mag, 1'b0});
`endif
        end else if (state == ST_CALC) begin
            acc_q   <= acc_nxt;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    // Product register: apply the sign once; negating zero yields zero so no special case is needed
    always_ff @(posedge aclk) begin
        if (areset) begin
            tdata_q <= '0;
        end else if (state == ST_SIGN) begin
            tdata_q <= neg_q ? -product : product;
        end
    end

    assign m_axis_tdata = tdata_q;

endmodule

// File: tb/tb_mult_axis.sv
// Self-checking bench for mult_axis: a signed 16x16 instance and an unsigned 16x15 instance.
// Latency: expected latency derived from the radix selected by MULT_RADIX4_EN.
// Backpressure: exercised through stalled and randomly toggled m_axis_tready.
module tb_mult_axis;

`ifdef MULT_RADIX4_EN
    localparam int LAT_S = (16 + 1) / 2 + 2;
    localparam int LAT_U = (15 + 1) / 2 + 2;
`else
    localparam int LAT_S = 16 + 2;
    localparam int LAT_U = 15 + 2;
`endif

    logic aclk   = 1'b0;
    logic areset = 1'b1;
    always #5 aclk = ~aclk;

    // Signed 16x16 instance
    logic [15:0] a_tdata, b_tdata;
    logic        a_tvalid, b_tvalid, a_tready, b_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready;

    // Unsigned 16x15 instance
    logic [15:0] ua_tdata;
    logic [14:0] ub_tdata;
    logic        ua_tvalid, ub_tvalid, ua_tready, ub_tready;
    logic [30:0] um_tdata;
    logic        um_tvalid, um_tready;

    int          tests_run;
    int          tests_failed;
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    bit          a_done, b_done;

    mult_axis #(
        .SYMBOL_A ("signed"),
        .SYMBOL_B ("signed"),
        .WIDTH_A  (16),
        .WIDTH_B  (16)
    ) u_dut_s (
        .aclk            (aclk),
        .areset          (areset),
        .s_axis_a_tdata  (a_tdata),
        .s_axis_a_tvalid (a_tvalid),
        .s_axis_a_tready (a_tready),
        .s_axis_b_tdata  (b_tdata),
        .s_axis_b_tvalid (b_tvalid),
        .s_axis_b_tready (b_tready),
        .m_axis_tdata    (m_tdata),
        .m_axis_tvalid   (m_tvalid),
        .m_axis_tready   (m_tready)
    );

    mult_axis #(
        .SYMBOL_A ("unsigned"),
        .SYMBOL_B ("unsigned"),
        .WIDTH_A  (16),
        .WIDTH_B  (15)
    ) u_dut_u (
        .aclk            (aclk),
        .areset          (areset),
        .s_axis_a_tdata  (ua_tdata),
        .s_axis_a_tvalid (ua_tvalid),
        .s_axis_a_tready (ua_tready),
        .s_axis_b_tdata  (ub_tdata),
        .s_axis_b_tvalid (ub_tvalid),
        .s_axis_b_tready (ub_tready),
        .m_axis_tdata    (um_tdata),
        .m_axis_tvalid   (um_tvalid),
        .m_axis_tready   (um_tready)
    );

    // Reference: exact integer products, truncated to the output width
    function automatic logic [31:0] ref_s(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[31:0];
    endfunction

    function automatic logic [30:0] ref_u(input logic [15:0] a, input logic [14:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[30:0];
    endfunction

    // Operand generator biased toward the corner values
    function automatic logic [15:0] pick16();
        case ($urandom_range(5, 0))
            0:       return 16'h8000;
            1:       return 16'hFFFF;
            2:       return 16'h0000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Scoreboard on the signed product stream; handshake is decided by the coming rising edge
    always @(negedge aclk) begin
        if (!areset && m_tvalid && m_tready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_output: got %h, none expected", m_tdata);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_tdata !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL product: got %h expected %h", m_tdata, mon_exp);
                end
            end
        end
    end

    task automatic drive_a(input logic [15:0] d, input int gap_max);
        int n;
        repeat ($urandom_range(gap_max, 0)) begin @(posedge aclk); #1; end
        a_tdata = d; a_tvalid = 1'b1; n = 0;
        while (!a_tready && n < 500) begin @(posedge aclk); #1; n++; end
        if (n >= 500) begin
            tests_run++; tests_failed++;
            $display("FAIL a_accept_timeout: got no tready in %0d cycles, required within 500", n);
        end
        @(posedge aclk); #1;
        a_tvalid = 1'b0;
    endtask

    task automatic drive_b(input logic [15:0] d, input int gap_max);
        int n;
        repeat ($urandom_range(gap_max, 0)) begin @(posedge aclk); #1; end
        b_tdata = d; b_tvalid = 1'b1; n = 0;
        while (!b_tready && n < 500) begin @(posedge aclk); #1; n++; end
        if (n >= 500) begin
            tests_run++; tests_failed++;
            $display("FAIL b_accept_timeout: got no tready in %0d cycles, required within 500", n);
        end
        @(posedge aclk); #1;
        b_tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin @(posedge aclk); #1; n++; end
        if (exp_q.size() != 0) begin
            tests_run++; tests_failed++;
            $display("FAIL drain: got %0d products outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge aclk); #1;
    endtask

    // Present both operands together to an idle core and measure the latency to tvalid
    task automatic run_pair_timed(input logic [15:0] a, input logic [15:0] b,
                                  input logic [31:0] exp, input string name);
        int n;
        m_tready = 1'b1;
        exp_q.push_back(exp);
        a_tdata = a; b_tdata = b; a_tvalid = 1'b1; b_tvalid = 1'b1;
        @(posedge aclk); #1;
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        n = 0;
        while (!m_tvalid && n < 200) begin @(posedge aclk); #1; n++; end
        tests_run++;
        if (n !== LAT_S) begin
            tests_failed++;
            $display("FAIL %s_latency: got %0d expected %0d", name, n, LAT_S);
        end
        drain(200);
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        tests_run++;
        if (a_tready !== 1'b0 || b_tready !== 1'b0 || ua_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_tready: got %b%b%b expected 000", a_tready, b_tready, ua_tready);
        end
        tests_run++;
        if (m_tvalid !== 1'b0 || m_tdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_output: got valid=%b data=%h expected 0/00000000", m_tvalid, m_tdata);
        end
        areset = 1'b0;
        #1;
        tests_run++;
        if (a_tready !== 1'b1 || b_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: got a_rdy=%b b_rdy=%b vld=%b expected 1/1/0", a_tready, b_tready, m_tvalid);
        end
    endtask

    task automatic test_basic();
        run_pair_timed(16'd15,   16'd3,    32'd45,        "u15x3");
        run_pair_timed(16'hFFF9, 16'd6,    32'hFFFFFFD6,  "neg7x6");
        run_pair_timed(16'h8000, 16'h8000, 32'h40000000,  "min_x_min");
        run_pair_timed(16'h8000, 16'd1,    32'hFFFF8000,  "min_x_1");
        run_pair_timed(16'h7FFF, 16'h8000, 32'hC0008000,  "max_x_min");
        run_pair_timed(16'h0000, 16'hFFFB, 32'h00000000,  "zero_x_neg");
        run_pair_timed(16'hFFFF, 16'hFFFF, 32'h00000001,  "neg1_x_neg1");
    endtask

    task automatic test_skewed();
        logic [15:0] a2, b2;
        int bad;
        m_tready = 1'b1;
        a2 = pick16(); b2 = pick16();
        exp_q.push_back(32'd162);
        exp_q.push_back(ref_s(a2, b2));
        a_tdata = 16'd27; a_tvalid = 1'b1;
        @(posedge aclk); #1;
        a_tvalid = 1'b0;
        bad = 0;
        repeat (10) begin
            @(posedge aclk); #1;
            if (a_tready !== 1'b0) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL skew_a_held: got tready high in %0d cycles, required 0", bad);
        end
        b_tdata = 16'd6; b_tvalid = 1'b1;
        @(posedge aclk); #1;
        b_tvalid = 1'b0;
        drive_a(a2, 0);
        tests_run++;
        if (m_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL skew_next_a_in_calc: got tvalid=%b at accept, expected 0", m_tvalid);
        end
        drive_b(b2, 0);
        drain(200);
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa[5];
        logic [15:0] pb[5];
        pa = '{16'd15, 16'd27, 16'd53, 16'd13, 16'd37};
        pb = '{16'd3,  16'd6,  16'd5,  16'd4,  16'd9};
        m_tready = 1'b0;
        exp_q.push_back(32'd45);
        exp_q.push_back(32'd162);
        exp_q.push_back(32'd265);
        exp_q.push_back(32'd52);
        exp_q.push_back(32'd333);
        fork
            begin for (int i = 0; i < 5; i++) drive_a(pa[i], 0); end
            begin for (int i = 0; i < 5; i++) drive_b(pb[i], 0); end
            begin
                repeat (40) begin
                    @(posedge aclk); #1;
                    if (m_tvalid) begin
                        tests_run++;
                        if (m_tdata !== 32'd45) begin
                            tests_failed++;
                            $display("FAIL stall_hold: got %h expected 0000002d", m_tdata);
                        end
                    end
                end
                tests_run++;
                if (m_tvalid !== 1'b1 || a_tready !== 1'b0 || b_tready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL stall_backpressure: got vld=%b a_rdy=%b b_rdy=%b expected 1/0/0",
                             m_tvalid, a_tready, b_tready);
                end
                m_tready = 1'b1;
            end
        join
        drain(500);
    endtask

    task automatic test_reset_mid();
        m_tready = 1'b1;
        a_tdata = 16'd53; b_tdata = 16'd5; a_tvalid = 1'b1; b_tvalid = 1'b1;
        @(posedge aclk); #1;
        a_tvalid = 1'b0; b_tvalid = 1'b0;
        @(posedge aclk); #1;
        // Buffer an operand that the reset must also discard
        a_tdata = 16'd99; a_tvalid = 1'b1;
        @(posedge aclk); #1;
        a_tvalid = 1'b0;
        repeat (4) begin @(posedge aclk); #1; end
        areset = 1'b1;
        #1;
        tests_run++;
        if (a_tready !== 1'b0 || b_tready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_tready: got %b%b expected 00", a_tready, b_tready);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
        #1;
        tests_run++;
        if (a_tready !== 1'b1 || m_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_flush: got a_rdy=%b vld=%b expected 1/0", a_tready, m_tvalid);
        end
        run_pair_timed(16'd13, 16'd4, 32'd52, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] ra[$];
        logic [15:0] rb[$];
        int n;
        for (int i = 0; i < 30; i++) begin
            ra.push_back(pick16());
            rb.push_back(pick16());
            exp_q.push_back(ref_s(ra[i], rb[i]));
        end
        a_done = 1'b0; b_done = 1'b0;
        fork
            begin for (int i = 0; i < 30; i++) drive_a(ra[i], 3); a_done = 1'b1; end
            begin for (int i = 0; i < 30; i++) drive_b(rb[i], 3); b_done = 1'b1; end
            begin
                n = 0;
                while (!(a_done && b_done && exp_q.size() == 0) && n < 5000) begin
                    m_tready = ($urandom_range(3, 0) != 0);
                    @(posedge aclk); #1;
                    n++;
                end
                m_tready = 1'b1;
            end
        join
        drain(500);
    endtask

    task automatic test_unsigned();
        logic [15:0] ta;
        logic [14:0] tb;
        logic [30:0] exp;
        int n;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       begin ta = 16'd15;   tb = 15'd3;      end
                1:       begin ta = 16'hFFFF; tb = 15'h7FFF;   end
                2:       begin ta = 16'h0000; tb = 15'h7FFF;   end
                3:       begin ta = 16'h8000; tb = 15'h4000;   end
                default: begin ta = 16'($urandom); tb = 15'($urandom); end
            endcase
            exp = ref_u(ta, tb);
            ua_tdata = ta; ub_tdata = tb; ua_tvalid = 1'b1; ub_tvalid = 1'b1;
            @(posedge aclk); #1;
            ua_tvalid = 1'b0; ub_tvalid = 1'b0;
            n = 0;
            while (!um_tvalid && n < 200) begin @(posedge aclk); #1; n++; end
            tests_run++;
            if (n !== LAT_U) begin
                tests_failed++;
                $display("FAIL unsigned_latency[%0d]: got %0d expected %0d", i, n, LAT_U);
            end
            tests_run++;
            if (um_tdata !== exp) begin
                tests_failed++;
                $display("FAIL unsigned_product[%0d]: %h*%h got %h expected %h", i, ta, tb, um_tdata, exp);
            end
            @(posedge aclk); #1;
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        a_tdata = '0; b_tdata = '0; a_tvalid = 1'b0; b_tvalid = 1'b0; m_tready = 1'b1;
        ua_tdata = '0; ub_tdata = '0; ua_tvalid = 1'b0; ub_tvalid = 1'b0; um_tready = 1'b1;
        a_done = 1'b0; b_done = 1'b0;
        test_reset();
        test_basic();
        test_skewed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_unsigned();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mult_axis.md
Name: mult_axis

Overview:
- Sequential fixed-point multiplier; the inverse-operation companion to the team's AXI-Stream divider, and shares its interface: operand streams A and B in, product stream out.
- Iterative shift-add core (one multiplier bit per cycle) with one-entry holding registers on each operand channel.
- Sits in the same arithmetic library as the divider and drops into the same testbench harness.

Parameters:
- SYMBOL_A, "signed", interpretation of A: "signed" (two's complement) or "unsigned".
- SYMBOL_B, "signed", interpretation of B: "signed" or "unsigned".
- WIDTH_A, 16, A operand width; legal range ≥2.
- WIDTH_B, 16, B operand width, which is also the iteration count; legal range ≥2.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  synchronous active-high reset.
- s_axis_a_tdata  in  WIDTH_A  operand A.
- s_axis_a_tvalid  in  1  A valid.
- s_axis_a_tready  out  1  A holding register empty.
- s_axis_b_tdata  in  WIDTH_B  operand B.
- s_axis_b_tvalid  in  1  B valid.
- s_axis_b_tready  out  1  B holding register empty.
- m_axis_tdata  out  WIDTH_A+WIDTH_B  product; two's complement if either operand is signed.
- m_axis_tvalid  out  1  product valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (areset high at an edge):
  - Both holding registers empty; FSM goes to IDLE; m_axis_tvalid=0; m_axis_tdata=0.
  - s_axis_*_tready are forced 0 while areset is high.
  - Reset mid-operation discards the in-flight product and any buffered operands; nothing is emitted for them.
- Input handshakes:
  - s_axis_x_tready = ~areset & ~buf_x_full, per channel and independently.
  - A beat is captured when tvalid & tready at the edge.
  - A and B may arrive in any order or in the same cycle. The n-th A pairs with the n-th B.
- FSM: IDLE → CALC → SIGN → OUT → IDLE.
  - IDLE: when buf_a_full & buf_b_full, load the core and clear both buffers (each becomes ready next cycle); go to CALC.
  - Load: a signed negative operand is converted to its magnitude as an unsigned value of the same width. -2^(W-1) becomes 2^(W-1) unsigned, with no overflow. The result sign is the XOR of the operand signs; an unsigned operand's sign is 0.
  - CALC: WIDTH_B iterations. Each adds mag_a to the accumulator when the current LSB of mag_b is 1, then shifts right. The accumulator is WIDTH_A+WIDTH_B+1 bits. Go to SIGN after the last iteration.
  - SIGN: negate the accumulator if the sign is set; register to m_axis_tdata; set m_axis_tvalid; go to OUT.
  - OUT: hold m_axis_tdata and m_axis_tvalid stable until m_axis_tready at an edge, then clear tvalid and go to IDLE.
- Latency: m_axis_tvalid rises WIDTH_B+2 edges after the edge completing the later input handshake, given an IDLE core.
- Throughput: one product per WIDTH_B+3 cycles minimum. The next operand pair may be buffered during CALC, SIGN or OUT.
- Arithmetic and width:
  - The product is exact; there is no truncation or saturation. Worst case |-2^(WA-1)·-2^(WB-1)| = 2^(WA+WB-2) fits.
  - The output is sign-extended to the full WIDTH_A+WIDTH_B.
  - Zero operand → result 0; sign is not applied to 0, so there is no negative zero issue in two's complement.
- Simultaneous events:
  - A buffer capture and a core load in the same edge cannot collide: ready=0 while the buffer is full.
  - Downstream m_axis_tready held low stalls indefinitely. Inputs then back-pressure after one buffered pair.

Optional Feature:
- Macro: MULT_RADIX4_EN.
- Defined:
  - CALC consumes 2 bits of mag_b per cycle, adding 0, a, 2a or 3a.
  - 3a is precomputed at load, WIDTH_A+2 bits.
  - mag_b is zero-extended to an even width.
  - CALC lasts ceil(WIDTH_B/2) cycles; latency is ceil(WIDTH_B/2)+2.
- Undefined: radix-2, as above.
- Results are bit-identical in both modes.

Decomposition:
- Shared package mult_pkg:
  - FSM state encoding: IDLE=0, CALC=1, SIGN=2, OUT=3.
  - Function is_signed(symbol) that maps "signed"/"unsigned" to 1/0.
  - Iteration-count constant function, radix-dependent.
  - The divider reuses is_signed.
- Sub-module mult_axis_buf: a one-entry AXIS holding register (data, full flag, tready), parameterized by width and instantiated for A and B.

Test Plan:
- Unsigned basic: SYMBOL_* "unsigned", A=15, B=3 → m_axis_tdata=45 (0x0000002D), tvalid 18 cycles after the joint handshake.
- Signed negatives: A=-7 (0xFFF9), B=6 → 0xFFFFFFD6. A=-32768, B=-32768 → 0x40000000. A=-32768, B=1 → 0xFFFF8000.
- Skewed arrival: A=27 accepted, B=6 presented 10 cycles later. → s_axis_a_tready stays 0 until the load; result 162; the next A is accepted during CALC.
- Back-pressure: stream the pairs (15,3), (27,6), (53,5), (13,4), (37,9) with m_axis_tready low for 40 cycles. → tdata 45 held stable; tready of both inputs drops after one buffered pair; outputs 45, 162, 265, 52, 333 in order.
- Reset mid-CALC: assert areset for 1 cycle, 5 cycles into CALC of 53×5. → no output for that pair, tready=0 during reset; the next pair 13×4 → 52 with nominal latency.
- MULT_RADIX4_EN defined: repeat scenarios 1–2 (including odd WIDTH_B=15) → identical results, latency ceil(WIDTH_B/2)+2.
